// File: rtl/pipe_if_id_skid_stage_pkg.sv
// rtl/pipe_if_id_skid_stage_pkg.sv - shared pipeline types and constants for the IF->ID stage
package pipe_if_id_skid_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_if_id_skid_stage_if.sv
// rtl/pipe_if_id_skid_stage_if.sv - IF->ID handshake bundle with fetch-side and decode-side signals
interface pipe_if_id_skid_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 30
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/pipe_if_id_skid_stage_skid_buf_2.sv
// rtl/pipe_if_id_skid_stage_skid_buf_2.sv - generic 2-entry valid/ready skid buffer with registered in_ready
module skid_buf_2
    import pipe_if_id_skid_stage_pkg::*;
#(
    parameter int DATA_W = 62
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    skid_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              in_ready_q;
    logic              in_fire;
    logic              load_main_in, load_main_skid, load_skid;

    assign in_fire   = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (clear) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_ready) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (out_ready) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid entry can move up
                    if (out_ready) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_BUSY;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (clear) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/pipe_if_id_skid_stage.sv
// rtl/pipe_if_id_skid_stage.sv - IF->ID pipeline register built on a 2-entry skid with flush and bubble insertion
module pipe_if_id_skid_stage
    import pipe_if_id_skid_stage_pkg::*;
#(
    parameter int                 INSTR_W = 32,
    parameter int                 PC_W    = 30,
    parameter logic [INSTR_W-1:0] BUBBLE  = INSTR_W'(NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    pipe_if_id_skid_stage_if.slave   bus
);
    localparam int DATA_W = INSTR_W + PC_W;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;

    skid_buf_2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .in_valid  (bus.in_valid),
        .in_data   ({bus.in_instr, bus.in_pc}),
        .in_ready  (bus.in_ready),
        .out_valid (main_valid),
        .out_data  (main_data),
        .out_ready (bus.out_ready)
    );

    // Decode never sees stale payload: an invalid slot always reads as a NOP bubble
    assign bus.out_valid = main_valid;
    assign bus.out_instr = main_valid ? main_data[DATA_W-1:PC_W] : BUBBLE;
    assign bus.out_pc    = main_valid ? main_data[PC_W-1:0] : '0;
endmodule
